// File: rtl/adc_avg_filter_pkg.sv
// ---------------------------------------------------------------------------
// adc_avg_filter_pkg
//   Constants and types shared by the ADC averaging filter and its
//   consumers (FF_Array, voltage_comparator, LCD). Keeping the sample width
//   and window size here means every consumer of V_AVG uses the same width.
// ---------------------------------------------------------------------------
package adc_avg_filter_pkg;

    // XADC conversion width
    localparam int ADC_DW         = 12;

    // Default log2 of the averaging window (N = 4 samples)
    localparam int ADC_AVG_LOG2_N = 2;

    // WARM: the window is not yet full.
    // RUN : the window holds N real samples.
    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } avg_state_t;

endpackage

// File: rtl/adc_avg_filter_ptr.sv
// ---------------------------------------------------------------------------
// adc_avg_filter_ptr
//   Wrap-around write pointer for the averaging window's circular buffer.
//   The window length is a power of two, so the natural binary rollover
//   provides the wrap from N-1 back to 0.
// Ports
//   i_clk    clock
//   i_rst_n  asynchronous reset, active-low (pointer -> 0)
//   i_clr    synchronous clear (pointer -> 0); has priority over i_inc
//   i_inc    advance the pointer by one
//   o_ptr    current pointer value
// ---------------------------------------------------------------------------
module adc_avg_filter_ptr #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/adc_avg_filter.sv
// ---------------------------------------------------------------------------
// adc_avg_filter
//   Moving-average filter over the last 2**LOG2_N XADC samples. It smooths
//   conversion noise so that downstream max-voltage tracking does not latch
//   onto single-sample spikes.
// Ports
//   i_clk        clock (pll_clk domain)
//   i_rst_n      asynchronous reset, active-low
//   i_drdy       one-cycle strobe: i_adc_data holds a new sample
//   i_adc_data   raw XADC result, unsigned
//   i_clr        synchronous flush of the window (wins over i_drdy)
//   o_v_avg      filtered voltage, registered, unsigned
//   o_avg_valid  one-cycle strobe: o_v_avg was just updated with a full-window average
//   o_filled     level: window holds N real samples
// ---------------------------------------------------------------------------
module adc_avg_filter
    import adc_avg_filter_pkg::*;
#(
    parameter int LOG2_N = ADC_AVG_LOG2_N,
    parameter int DW     = ADC_DW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_drdy,
    input  logic [DW-1:0] i_adc_data,
    input  logic          i_clr,
    output logic [DW-1:0] o_v_avg,
    output logic          o_avg_valid,
    output logic          o_filled
);

    localparam int N  = 1 << LOG2_N;
    localparam int SW = DW + LOG2_N;   // holds N full-scale samples without overflow

    logic [DW-1:0]     r_buf [N];
    logic [SW-1:0]     r_sum;
    logic [LOG2_N:0]   r_fill;
    logic              r_pend;
    logic [DW-1:0]     r_v_avg;
    logic              r_avg_valid;
    avg_state_t        r_state;
    avg_state_t        w_state_next;

    logic              w_accept;
    logic [LOG2_N-1:0] w_wr_ptr;
    logic [DW-1:0]     w_old;
    logic              w_filled;

    assign w_accept = i_drdy & ~i_clr;

    adc_avg_filter_ptr #(
        .W (LOG2_N)
    ) u_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr),
        .i_inc   (w_accept),
        .o_ptr   (w_wr_ptr)
    );

    // The entry about to be overwritten leaves the running sum in the same
    // cycle the new sample enters it.
    assign w_old = r_buf[w_wr_ptr];

    // Circular buffer. Entries are cleared on CLR so that the running sum
    // always equals the sum of the buffer contents.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
        end else if (i_clr) begin
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_accept) begin
            r_buf[w_wr_ptr] <= i_adc_data;
        end
    end

    // Running sum and saturating fill count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum  <= '0;
            r_fill <= '0;
        end else if (i_clr) begin
            r_sum  <= '0;
            r_fill <= '0;
        end else if (w_accept) begin
            r_sum <= r_sum + SW'(i_adc_data) - SW'(w_old);
            if (r_fill != (LOG2_N+1)'(N)) begin
                r_fill <= r_fill + (LOG2_N+1)'(1);
            end
        end
    end

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_WARM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state. Enter RUN on the edge that stores the Nth sample.
    always_comb begin
        w_state_next = r_state;
        if (i_clr) begin
            w_state_next = ST_WARM;
        end else begin
            case (r_state)
                ST_WARM: begin
                    if (w_accept && (r_fill == (LOG2_N+1)'(N - 1))) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN:  w_state_next = ST_RUN;
                default: w_state_next = ST_WARM;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        w_filled = 1'b0;
        if (r_state == ST_RUN) begin
            w_filled = 1'b1;
        end
    end

    // Output stage, one edge behind the accept edge. A CLR arriving while a
    // result is pending suppresses it and leaves o_v_avg untouched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend      <= 1'b0;
            r_v_avg     <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_pend      <= w_accept;
            r_avg_valid <= 1'b0;
            if (r_pend && w_filled && !i_clr) begin
                r_v_avg     <= r_sum[SW-1:LOG2_N];
                r_avg_valid <= 1'b1;
            end
        end
    end

    assign o_v_avg     = r_v_avg;
    assign o_avg_valid = r_avg_valid;
    assign o_filled    = w_filled;

endmodule
